aurora_rx_nfc_buffer: RTL and testbench
=======================================

Name: aurora_rx_nfc_buffer

Overview:
- Sits between the Aurora 8b10b core RX user interface and downstream consumers in the user_clk domain.
- The core's RX stream has no backpressure. This block buffers it in a FIFO and presents it as an AXI4-Stream master with tready.
- Drives the core's NFC TX port to issue XOFF to the link partner when fill rises and XON when it drains, closing the flow-control loop the partner's transmitter obeys.

Parameters:
- DEPTH_LOG2, 9, FIFO depth is 2**DEPTH_LOG2 words (each word is 32 data + 4 keep + 1 last).
- XOFF_LEVEL, 448, fill level (words) at or above which XOFF is requested.
- XON_LEVEL, 256, fill level at or below which XON is requested. Must be < XOFF_LEVEL.
- REFRESH_CYCLES, 4096, period for re-sending XOFF while paused. 0 disables refresh.

Ports:
- user_clk  in  1  sole clock; Aurora user clock.
- reset_n  in  1  asynchronous, active-low reset.
- channel_up  in  1  core channel status.
- rx_tdata  in  [0:31]  core m_axi_rx_tdata, bit 0 MSB.
- rx_tkeep  in  [0:3]  core m_axi_rx_tkeep.
- rx_tlast  in  1  core m_axi_rx_tlast.
- rx_tvalid  in  1  core m_axi_rx_tvalid.
- m_tdata  out  [0:31]  buffered stream data.
- m_tkeep  out  [0:3]  buffered keep.
- m_tlast  out  1  buffered last.
- m_tvalid  out  1  buffered valid.
- m_tready  in  1  downstream ready.
- nfc_tvalid  out  1  to core s_axi_nfc_tx_tvalid.
- nfc_tdata  out  [0:3]  to core s_axi_nfc_tx_tdata.
- nfc_tready  in  1  from core s_axi_nfc_tx_tready.
- level  out  DEPTH_LOG2+1  current fill in words.
- paused  out  1  high while the partner is held in XOFF.
- overflow  out  1  sticky: a word was dropped.
- drop_count  out  16  saturating count of dropped words.
- ovf_clr  in  1  single-cycle clear of overflow and drop_count.

Behaviour:
- Reset (reset_n low, async): all outputs 0, FIFO empty, NFC FSM in XON_ST.

Write path:
- rx_tvalid high → word written the same edge if level < 2**DEPTH_LOG2, or if level is full and a read handshake occurs in that same cycle.
- Otherwise the word is dropped: overflow set to 1, drop_count incremented, saturating at 16'hFFFF.

Read path:
- Output-registered FIFO. A word written at edge N is visible on m_* after edge N+1 when the FIFO was empty.
- A read handshake occurs when m_tvalid & m_tready.
- m_* hold stable while m_tvalid & !m_tready.

Level and clears:
- level counts words stored, including the output register.
- Simultaneous write and read leaves level unchanged.
- ovf_clr has priority over a same-cycle drop: the result is overflow=0, drop_count=0.

NFC FSM:
- XON_ST: level >= XOFF_LEVEL → SEND_XOFF.
- SEND_XOFF: nfc_tvalid=1, nfc_tdata=4'hF. On nfc_tready → XOFF_ST, paused=1, refresh counter cleared.
- XOFF_ST:
  - level <= XON_LEVEL → SEND_XON.
  - else if REFRESH_CYCLES≠0 and the counter reaches REFRESH_CYCLES-1 → SEND_XOFF (paused stays 1).
- SEND_XON: nfc_tvalid=1, nfc_tdata=4'h0. On nfc_tready → XON_ST, paused=0.
- nfc_tdata is constant while nfc_tvalid is high. A level change mid-request takes effect only after the handshake; the next state is then re-evaluated against level on the following cycle.
- Latency: the first cycle with level >= XOFF_LEVEL → nfc_tvalid asserted the next cycle.

Channel down:
- channel_up low → FIFO flushed (level=0, m_tvalid=0), FSM forced to XON_ST, paused=0, nfc_tvalid=0.
- overflow and drop_count are kept.
- Incoming words are ignored while channel_up is low.

Reset mid-operation: an asserted reset_n low aborts any pending NFC request immediately; no handshake completion is required.

Decomposition:
- Shared package aurora_pkg:
  - NFC_XOFF=4'hF and NFC_XON=4'h0.
  - FSM state enum {XON_ST, SEND_XOFF, XOFF_ST, SEND_XON}.
  - RX word struct {data[0:31], keep[0:3], last}.
- One sub-module: aurora_rx_fifo (synchronous FIFO with output register, level, flush input).
- The NFC FSM, drop logic and counters stay in the top module.

Test Plan:
- Reset release, then 10 rx words with m_tready=1 → each appears on m_* one cycle after write, level never exceeds 2, nfc_tvalid stays 0.
- m_tready=0, stream 448 words → nfc_tvalid=1 with tdata=4'hF on the cycle after level hits 448. With nfc_tready=1 for that cycle, paused=1.
- From paused with level 500, m_tready=1 → SEND_XON when level reaches 256, nfc_tdata=4'h0; paused=0 after handshake.
- Hold nfc_tready=0 for 20 cycles during SEND_XOFF while level keeps changing → nfc_tdata stable at 4'hF, then a single handshake.
- m_tready=0, 520 words into depth 512 → 8 dropped, overflow=1, drop_count=8. Then ovf_clr pulse → both 0.
- Paused with REFRESH_CYCLES=16 and level held at 480 → XOFF re-sent every 16 cycles. Then channel_up drop → level=0, m_tvalid=0, paused=0, drop_count retained.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared types and constants for the Aurora RX buffering / native flow control slice.
package aurora_pkg;

    localparam logic [0:3] NFC_XOFF = 4'hF;
    localparam logic [0:3] NFC_XON  = 4'h0;

    typedef enum logic [1:0] {
        XON_ST,
        SEND_XOFF,
        XOFF_ST,
        SEND_XON
    } nfc_state_e;

    typedef struct packed {
        logic [0:31] data;
        logic [0:3]  keep;
        logic        last;
    } rx_word_t;

endpackage

// File: rtl/aurora_rx_fifo.sv
// Synchronous FIFO with a registered output stage; level counts the output register too.
module aurora_rx_fifo
    import aurora_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                wr_en,
    input  rx_word_t            wr_word,
    input  logic                rd_ready,
    output rx_word_t            rd_word,
    output logic                rd_valid,
    output logic [DEPTH_LOG2:0] level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    rx_word_t              mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q;
    logic                  out_valid_q;
    rx_word_t              out_word_q;

    logic rd_hs;
    logic mem_has;
    logic pop;

    always_comb begin
        rd_hs   = out_valid_q & rd_ready;
        // Words held in memory are everything counted except the output register.
        mem_has = level_q > {{DEPTH_LOG2{1'b0}}, out_valid_q};
        pop     = mem_has & (~out_valid_q | rd_hs);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                out_word_q  <= mem[rd_ptr_q];
                out_valid_q <= 1'b1;
            end else if (rd_hs) begin
                out_valid_q <= 1'b0;
            end
            level_q <= level_q + {{DEPTH_LOG2{1'b0}}, wr_en} - {{DEPTH_LOG2{1'b0}}, rd_hs};
        end
    end

    assign rd_word  = out_word_q;
    assign rd_valid = out_valid_q;
    assign level    = level_q;

endmodule

// File: rtl/aurora_rx_nfc_buffer.sv
// Buffers the backpressure-free Aurora RX stream and drives NFC XOFF/XON from FIFO fill.
module aurora_rx_nfc_buffer
    import aurora_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2     = 9,
    parameter int unsigned XOFF_LEVEL     = 448,
    parameter int unsigned XON_LEVEL      = 256,
    parameter int unsigned REFRESH_CYCLES = 4096
) (
    input  logic                user_clk,
    input  logic                reset_n,
    input  logic                channel_up,
    input  logic [0:31]         rx_tdata,
    input  logic [0:3]          rx_tkeep,
    input  logic                rx_tlast,
    input  logic                rx_tvalid,
    output logic [0:31]         m_tdata,
    output logic [0:3]          m_tkeep,
    output logic                m_tlast,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                nfc_tvalid,
    output logic [0:3]          nfc_tdata,
    input  logic                nfc_tready,
    output logic [DEPTH_LOG2:0] level,
    output logic                paused,
    output logic                overflow,
    output logic [15:0]         drop_count,
    input  logic                ovf_clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [LVL_W-1:0] FULL_LVL     = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] XOFF_LVL     = LVL_W'(XOFF_LEVEL);
    localparam logic [LVL_W-1:0] XON_LVL      = LVL_W'(XON_LEVEL);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    rx_word_t wr_word;
    rx_word_t rd_word;
    logic     rd_hs;
    logic     accept;
    logic     drop;

    nfc_state_e       state_q, state_d;
    logic             paused_q, paused_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic             overflow_q;
    logic [15:0]      drop_count_q;

    assign wr_word = '{data: rx_tdata, keep: rx_tkeep, last: rx_tlast};

    // A full FIFO still takes a word when the output register drains on the same edge.
    always_comb begin
        rd_hs  = m_tvalid & m_tready;
        accept = rx_tvalid & channel_up & ((level != FULL_LVL) | rd_hs);
        drop   = rx_tvalid & channel_up & ~accept;
    end

    aurora_rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk     (user_clk),
        .rst_n   (reset_n),
        .flush   (~channel_up),
        .wr_en   (accept),
        .wr_word (wr_word),
        .rd_ready(m_tready),
        .rd_word (rd_word),
        .rd_valid(m_tvalid),
        .level   (level)
    );

    assign m_tdata = rd_word.data;
    assign m_tkeep = rd_word.keep;
    assign m_tlast = rd_word.last;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (ovf_clr) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        paused_d   = paused_q;
        refresh_d  = refresh_q;
        nfc_tvalid = 1'b0;
        nfc_tdata  = NFC_XON;
        unique case (state_q)
            XON_ST: begin
                if (level >= XOFF_LVL) begin
                    state_d = SEND_XOFF;
                end
            end
            SEND_XOFF: begin
                nfc_tvalid = 1'b1;
                nfc_tdata  = NFC_XOFF;
                if (nfc_tready) begin
                    state_d   = XOFF_ST;
                    paused_d  = 1'b1;
                    refresh_d = '0;
                end
            end
            XOFF_ST: begin
                if (level <= XON_LVL) begin
                    state_d = SEND_XON;
                end else if ((REFRESH_CYCLES != 0) && (refresh_q == REFRESH_LAST)) begin
                    state_d = SEND_XOFF;
                end else begin
                    refresh_d = refresh_q + 1'b1;
                end
            end
            SEND_XON: begin
                nfc_tvalid = 1'b1;
                nfc_tdata  = NFC_XON;
                if (nfc_tready) begin
                    state_d  = XON_ST;
                    paused_d = 1'b0;
                end
            end
            default: state_d = XON_ST;
        endcase
        // Link loss abandons any request; the partner restarts unpaused.
        if (!channel_up) begin
            state_d    = XON_ST;
            paused_d   = 1'b0;
            refresh_d  = '0;
            nfc_tvalid = 1'b0;
            nfc_tdata  = NFC_XON;
        end
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= XON_ST;
            paused_q  <= 1'b0;
            refresh_q <= '0;
        end else begin
            state_q   <= state_d;
            paused_q  <= paused_d;
            refresh_q <= refresh_d;
        end
    end

    assign paused     = paused_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_aurora_rx_nfc_buffer.sv
// Directed and randomized bench for aurora_rx_nfc_buffer against a queue-based reference model.
module tb_aurora_rx_nfc_buffer;

    localparam int DEPTH   = 512;
    localparam int XOFF    = 448;
    localparam int XON     = 256;
    localparam int REFRESH = 16;

    logic        user_clk = 1'b0;
    logic        reset_n;
    logic        channel_up;
    logic [0:31] rx_tdata;
    logic [0:3]  rx_tkeep;
    logic        rx_tlast;
    logic        rx_tvalid;
    logic [0:31] m_tdata;
    logic [0:3]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic        nfc_tvalid;
    logic [0:3]  nfc_tdata;
    logic        nfc_tready;
    logic [9:0]  level;
    logic        paused;
    logic        overflow;
    logic [15:0] drop_count;
    logic        ovf_clr;

    always #5 user_clk = ~user_clk;

    aurora_rx_nfc_buffer #(
        .DEPTH_LOG2    (9),
        .XOFF_LEVEL    (XOFF),
        .XON_LEVEL     (XON),
        .REFRESH_CYCLES(REFRESH)
    ) dut (
        .user_clk  (user_clk),
        .reset_n   (reset_n),
        .channel_up(channel_up),
        .rx_tdata  (rx_tdata),
        .rx_tkeep  (rx_tkeep),
        .rx_tlast  (rx_tlast),
        .rx_tvalid (rx_tvalid),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .nfc_tvalid(nfc_tvalid),
        .nfc_tdata (nfc_tdata),
        .nfc_tready(nfc_tready),
        .level     (level),
        .paused    (paused),
        .overflow  (overflow),
        .drop_count(drop_count),
        .ovf_clr   (ovf_clr)
    );

    // Reference model: stored words tagged with the edge they were written on.
    typedef struct {
        logic [36:0] w;
        int          stamp;
    } ent_t;

    ent_t q[$];
    int   edge_n;
    bit   exp_valid;
    bit   exp_paused;
    int   exp_req;     // 0 none, 1 XOFF pending, 2 XON pending
    int   exp_timer;
    bit   exp_ovf;
    int   exp_drops;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_valid  = 0;
        exp_paused = 0;
        exp_req    = 0;
        exp_timer  = 0;
        exp_ovf    = 0;
        exp_drops  = 0;
    endtask

    task automatic model_edge();
        int   lvl;
        bit   hs;
        bit   room;
        ent_t e;
        lvl  = q.size();
        hs   = exp_valid && m_tready;
        room = (lvl < DEPTH) || hs;
        if (!channel_up) begin
            exp_req    = 0;
            exp_paused = 0;
        end else if (exp_req != 0) begin
            if (nfc_tready) begin
                if (exp_req == 1) begin
                    exp_paused = 1;
                    exp_timer  = 0;
                end else begin
                    exp_paused = 0;
                end
                exp_req = 0;
            end
        end else if (!exp_paused) begin
            if (lvl >= XOFF) exp_req = 1;
        end else if (lvl <= XON) begin
            exp_req = 2;
        end else if (exp_timer == REFRESH - 1) begin
            exp_req = 1;
        end else begin
            exp_timer++;
        end
        if (ovf_clr) begin
            exp_ovf   = 0;
            exp_drops = 0;
        end else if (rx_tvalid && channel_up && !room) begin
            exp_ovf = 1;
            if (exp_drops < 65535) exp_drops++;
        end
        if (hs) void'(q.pop_front());
        if (!channel_up) begin
            q.delete();
        end else if (rx_tvalid && room) begin
            e.w     = {rx_tdata, rx_tkeep, rx_tlast};
            e.stamp = edge_n;
            q.push_back(e);
        end
        // A word becomes visible no earlier than the edge after it was written.
        exp_valid = (q.size() > 0) && (q[0].stamp < edge_n);
        edge_n++;
    endtask

    task automatic check_outputs();
        check("m_tvalid", m_tvalid, exp_valid);
        check("level", level, q.size());
        if (exp_valid) check("m_word", {m_tdata, m_tkeep, m_tlast}, q[0].w);
        check("nfc_tvalid", nfc_tvalid, exp_req != 0);
        if (exp_req != 0) check("nfc_tdata", nfc_tdata, (exp_req == 1) ? 4'hF : 4'h0);
        check("paused", paused, exp_paused);
        check("overflow", overflow, exp_ovf);
        check("drop_count", drop_count, exp_drops);
    endtask

    task automatic cycle();
        @(posedge user_clk);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic rand_word();
        rx_tdata = $urandom;
        rx_tkeep = 4'($urandom_range(0, 15));
        rx_tlast = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int  maxlvl;
        bit  ok;
        int  low_run;
        int  pulses;
        int  fill_pct;
        int  rdy_pct;
        reset_n    = 1'b0;
        channel_up = 1'b0;
        rx_tvalid  = 1'b0;
        rx_tdata   = '0;
        rx_tkeep   = '0;
        rx_tlast   = 1'b0;
        m_tready   = 1'b0;
        nfc_tready = 1'b0;
        ovf_clr    = 1'b0;
        edge_n     = 0;
        model_reset();

        repeat (3) @(posedge user_clk);
        #1;
        check_outputs();
        check("rst_m_tdata", m_tdata, 0);
        check("rst_nfc_tdata", nfc_tdata, 0);
        reset_n = 1'b1;

        // Ten words straight through with the consumer ready.
        channel_up = 1'b1;
        m_tready   = 1'b1;
        nfc_tready = 1'b1;
        maxlvl     = 0;
        for (int i = 0; i < 13; i++) begin
            rx_tvalid = (i < 10);
            rand_word();
            cycle();
            if (int'(level) > maxlvl) maxlvl = int'(level);
        end
        check("pass_level_le2", maxlvl <= 2, 1);

        // Fill to the XOFF threshold with the consumer stalled.
        m_tready  = 1'b0;
        rx_tvalid = 1'b1;
        for (int i = 0; i < 600 && q.size() < XOFF; i++) begin
            rand_word();
            cycle();
        end
        check("fill_448", level, XOFF);
        check("no_xoff_yet", nfc_tvalid, 0);
        rx_tvalid = 1'b0;
        cycle();
        check("xoff_req", {nfc_tvalid, nfc_tdata}, 5'b1_1111);
        cycle();
        check("paused_after_xoff", paused, 1);

        // Top up to 500, then drain until XON is requested.
        rx_tvalid = 1'b1;
        for (int i = 0; i < 100 && q.size() < 500; i++) begin
            rand_word();
            cycle();
        end
        rx_tvalid = 1'b0;
        m_tready  = 1'b1;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            cycle();
            ok = nfc_tvalid && (nfc_tdata == 4'h0);
        end
        check("xon_seen", ok, 1);
        check("xon_level", level <= XON, 1);
        cycle();
        check("unpaused_after_xon", paused, 0);

        // XOFF held pending for 20 cycles while the level moves.
        nfc_tready = 1'b0;
        m_tready   = 1'b0;
        rx_tvalid  = 1'b1;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            rand_word();
            cycle();
            ok = nfc_tvalid;
        end
        check("xoff_pending_seen", ok, 1);
        for (int i = 0; i < 20; i++) begin
            rx_tvalid = 1'($urandom_range(0, 1));
            m_tready  = 1'($urandom_range(0, 1));
            rand_word();
            cycle();
            check("xoff_hold_tdata", nfc_tdata, 4'hF);
        end
        nfc_tready = 1'b1;
        rx_tvalid  = 1'b0;
        m_tready   = 1'b0;
        cycle();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (nfc_tvalid) pulses++;
        end
        check("single_handshake", pulses, 0);

        // Drain to empty, then push 520 words into 512 slots.
        m_tready = 1'b1;
        for (int i = 0; i < 1000 && (q.size() != 0 || exp_valid); i++) cycle();
        check("drained", level, 0);
        m_tready  = 1'b0;
        rx_tvalid = 1'b1;
        for (int i = 0; i < 520; i++) begin
            rand_word();
            cycle();
        end
        check("ovf_set", overflow, 1);
        check("ovf_count8", drop_count, 8);
        ovf_clr = 1'b1;
        rand_word();
        cycle();
        ovf_clr = 1'b0;
        check("clr_beats_drop_ovf", overflow, 0);
        check("clr_beats_drop_cnt", drop_count, 0);
        for (int i = 0; i < 3; i++) begin
            rand_word();
            cycle();
        end
        check("ovf_count3", drop_count, 3);

        // Hold level at 480 while paused and watch the XOFF refresh cadence.
        rx_tvalid = 1'b0;
        m_tready  = 1'b1;
        for (int i = 0; i < 100 && q.size() > 480; i++) cycle();
        m_tready = 1'b0;
        check("hold_480", level, 480);
        low_run = -1;
        pulses  = 0;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (nfc_tvalid) begin
                if (low_run > 0) begin
                    check("refresh_gap", low_run, REFRESH);
                    pulses++;
                end
                low_run = 0;
            end else if (low_run >= 0) begin
                low_run++;
            end
        end
        check("refresh_pulses", pulses >= 3, 1);
        check("refresh_paused", paused, 1);

        // Channel loss flushes the FIFO, unpauses and ignores input.
        channel_up = 1'b0;
        rx_tvalid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_word();
            cycle();
        end
        check("chdn_level", level, 0);
        check("chdn_m_tvalid", m_tvalid, 0);
        check("chdn_paused", paused, 0);
        check("chdn_drops_kept", drop_count, 3);

        // Randomized traffic alternating fill and drain phases.
        channel_up = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (((i / 600) % 2) == 0) begin
                fill_pct = 85;
                rdy_pct  = 5;
            end else begin
                fill_pct = 40;
                rdy_pct  = 95;
            end
            channel_up = ($urandom_range(0, 1499) != 0);
            rx_tvalid  = ($urandom_range(0, 99) < fill_pct);
            m_tready   = ($urandom_range(0, 99) < rdy_pct);
            nfc_tready = ($urandom_range(0, 9) < 7);
            ovf_clr    = ($urandom_range(0, 99) == 0);
            rand_word();
            cycle();
        end
        ovf_clr = 1'b0;

        // Reset asserted while an NFC request is still pending.
        channel_up = 1'b1;
        nfc_tready = 1'b0;
        m_tready   = 1'b0;
        rx_tvalid  = 1'b1;
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            rand_word();
            cycle();
            ok = nfc_tvalid;
        end
        check("pending_before_reset", ok, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_abort_nfc", nfc_tvalid, 0);
        check("rst_abort_paused", paused, 0);
        check("rst_abort_level", level, 0);
        model_reset();
        rx_tvalid = 1'b0;
        @(negedge user_clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
